// File: rtl/up_pkg.sv
// Shared processor project constants.
// Holds the debounce defaults used by the input conditioning logic.
package up_pkg;

    localparam int DB_COUNT_DEFAULT = 50000;
    localparam int DB_CNT_W = 16;

    typedef logic [DB_CNT_W-1:0] dbCnt_t;

endpackage

// File: rtl/debounce_1b.sv
// Single-bit switch conditioner.
// Two-flop synchronizer, saturating debounce counter and press pulse.
module debounce_1b
    import up_pkg::*;
#(
    parameter int DB_COUNT   = DB_COUNT_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic rawBit,
    output logic level,
    output logic pressPulse,
    output logic counting
);

    localparam dbCnt_t LAST = dbCnt_t'(DB_COUNT - 1);

    logic   rawAdj;
    logic   sync1;
    logic   sync2;
    logic   state;
    dbCnt_t cnt;

    assign rawAdj = ACTIVE_LOW ? ~rawBit : rawBit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            state      <= 1'b0;
            cnt        <= '0;
            pressPulse <= 1'b0;
        end else begin
            sync1      <= rawAdj;
            sync2      <= sync1;
            pressPulse <= 1'b0;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Only a rising debounced level produces a pulse.
                state      <= ~state;
                cnt        <= '0;
                pressPulse <= ~state;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level    = state;
    assign counting = |cnt;

endmodule

// File: rtl/pushbutton_conditioner.sv
// Four-button conditioner feeding the processor input bus.
// Debounced levels are re-registered only during fetch.
module pushbutton_conditioner
    import up_pkg::*;
#(
    parameter int DB_COUNT   = DB_COUNT_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_buttons,
    input  logic       phase,
    output logic [3:0] pushbuttons,
    output logic [3:0] debounced,
    output logic [3:0] press_pulse,
    output logic       busy
);

    logic [3:0] counting;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        debounce_1b #(
            .DB_COUNT  (DB_COUNT),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_db (
            .clock     (clock),
            .reset     (reset),
            .rawBit    (raw_buttons[i]),
            .level     (debounced[i]),
            .pressPulse(press_pulse[i]),
            .counting  (counting[i])
        );
    end

    // Hold through execute so the processor sees a stable input word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pushbuttons <= 4'b0000;
        end else if (!phase) begin
            pushbuttons <= debounced;
        end
    end

    assign busy = |counting;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for the pushbutton conditioner.
// Runs with DB_COUNT=4; a second instance covers the inverted input.
module tb_pushbutton_conditioner;

    logic       clock;
    logic       reset;
    logic       phase;
    logic [3:0] raw;
    logic [3:0] rawN;
    logic [3:0] pushbuttons;
    logic [3:0] debounced;
    logic [3:0] press_pulse;
    logic       busy;
    logic [3:0] pushbuttonsN;
    logic [3:0] debouncedN;
    logic [3:0] press_pulseN;
    logic       busyN;

    int nChecks = 0;
    int nBad    = 0;

    pushbutton_conditioner #(
        .DB_COUNT  (4),
        .ACTIVE_LOW(1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .raw_buttons(raw),
        .phase      (phase),
        .pushbuttons(pushbuttons),
        .debounced  (debounced),
        .press_pulse(press_pulse),
        .busy       (busy)
    );

    pushbutton_conditioner #(
        .DB_COUNT  (4),
        .ACTIVE_LOW(1'b1)
    ) dutN (
        .clock      (clock),
        .reset      (reset),
        .raw_buttons(rawN),
        .phase      (phase),
        .pushbuttons(pushbuttonsN),
        .debounced  (debouncedN),
        .press_pulse(press_pulseN),
        .busy       (busyN)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        logic busySeen;
        logic [3:0] pulseAcc;

        reset = 1'b1;
        phase = 1'b0;
        raw   = 4'b0000;
        rawN  = 4'b1111;
        #3;
        chk("rst_deb", 8'(debounced), 8'h0);
        chk("rst_pulse", 8'(press_pulse), 8'h0);
        chk("rst_pb", 8'(pushbuttons), 8'h0);
        chk("rst_busy", 8'(busy), 8'h0);
        doReset();

        // Basic press: raw set before edge 0.
        raw = 4'b0001;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e == 3) chk("p_busy3", 8'(busy), 8'h1);
            if (e == 4) chk("p_deb4", 8'(debounced), 8'h0);
            if (e == 5) begin
                chk("p_deb5", 8'(debounced), 8'h1);
                chk("p_pulse5", 8'(press_pulse), 8'h1);
                chk("p_pb5", 8'(pushbuttons), 8'h0);
                chk("p_busy5", 8'(busy), 8'h0);
            end
            if (e == 6) begin
                chk("p_pulse6", 8'(press_pulse), 8'h0);
                chk("p_pb6", 8'(pushbuttons), 8'h1);
            end
        end

        // Glitch on bit 2 lasting 3 clocks.
        busySeen = 1'b0;
        pulseAcc = 4'b0000;
        raw = 4'b0101;
        for (int e = 0; e < 14; e++) begin
            step();
            if (e == 2) raw = 4'b0001;
            busySeen = busySeen | busy;
            pulseAcc = pulseAcc | press_pulse;
        end
        chk("g_busy_seen", 8'(busySeen), 8'h1);
        chk("g_pulse", 8'(pulseAcc), 8'h0);
        chk("g_deb", 8'(debounced), 8'h1);
        chk("g_pb", 8'(pushbuttons), 8'h1);
        chk("g_busy_end", 8'(busy), 8'h0);

        // Debounced changes on an execute edge.
        doReset();
        raw = 4'b1000;
        for (int e = 0; e <= 6; e++) begin
            phase = e[0];
            step();
            if (e == 5) begin
                chk("ph_deb5", 8'(debounced), 8'h8);
                chk("ph_pb5", 8'(pushbuttons), 8'h0);
            end
            if (e == 6) chk("ph_pb6", 8'(pushbuttons), 8'h8);
        end
        phase = 1'b0;

        // Reset mid-count with bits 0 and 3 both counting.
        raw = 4'b0001;
        for (int e = 0; e < 4; e++) step();
        chk("r_busy_pre", 8'(busy), 8'h1);
        #2 reset = 1'b1;
        #1;
        chk("r_deb", 8'(debounced), 8'h0);
        chk("r_pb", 8'(pushbuttons), 8'h0);
        chk("r_busy", 8'(busy), 8'h0);
        chk("r_pulse", 8'(press_pulse), 8'h0);
        step();
        step();
        reset = 1'b0;
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            pulses += int'(press_pulse[0]);
            if (e == 4) chk("r_deb4", 8'(debounced), 8'h0);
            if (e == 5) chk("r_deb5", 8'(debounced), 8'h1);
        end
        chk("r_npulse", 8'(pulses), 8'h1);

        // Inverted inputs.
        doReset();
        rawN = 4'b1110;
        for (int e = 0; e < 8; e++) step();
        chk("n_deb", 8'(debouncedN), 8'h1);
        rawN = 4'b1111;
        for (int e = 0; e < 8; e++) step();
        chk("n_deb0", 8'(debouncedN), 8'h0);
        rawN = 4'b0000;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e == 4) chk("n_pulse4", 8'(press_pulseN), 8'h0);
            if (e == 5) begin
                chk("n_pulse5", 8'(press_pulseN), 8'hF);
                chk("n_deb5", 8'(debouncedN), 8'hF);
            end
            if (e == 6) chk("n_pulse6", 8'(press_pulseN), 8'h0);
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
